mem_lsu_sb: RTL and testbench
=============================

Name: mem_lsu_sb

Overview:
Parametrised memory-access stage for the RISC-V pipeline, sitting between the ex_mem and mem_wb latches and in front of the memory controller. It replaces the fully combinational single-access MEM stage with a registered request FSM and a store buffer. Stores retire without stalling, and loads are forwarded from or ordered against buffered stores. It also provides the MEM→ID forwarding path.

Parameters:
XLEN, 32, data width in bits; a multiple of 8, at least 32.
ADDR_W, 32, byte-address width.
SB_DEPTH, 4, store-buffer entries; a power of two, at least 2.

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous reset, active-high
rdy_in  in  1  global enable; when low, all state and registered outputs hold
valid_in  in  1  an instruction is present from ex_mem
is_load_in  in  1  load op
is_store_in  in  1  store op
size_in  in  2  access size: 0=byte, 1=half, 2=word
unsigned_in  in  1  zero-extend the load result (LBU/LHU)
mem_addr_in  in  ADDR_W  byte address, naturally aligned
storedata_in  in  XLEN  store data, right-justified
input_rd_addr  in  5  destination register
input_rd_data  in  XLEN  ALU result for non-load ops
write_or_not  in  1  rd write enable
out_rd_addr  out  5  to mem_wb
out_rd_data  out  XLEN  to mem_wb
out_write_or_not  out  1  to mem_wb
mem_forward_id_o  out  1  forward valid to ID
mem_forward_addr_o  out  5  forward register address
mem_forward_data_o  out  XLEN  forward data
stall_from_mem  out  1  to stallctrl
sb_empty_o  out  1  store buffer empty and no drain in flight (for fence/ecall)
read_mem  out  1  load request to mem ctrl (registered)
write_mem  out  1  store request to mem ctrl (registered)
mem_addr_to_read  out  ADDR_W  request address (registered)
mem_data_to_write  out  XLEN  store data (registered)
data_len  out  3  byte count 1/2/4 for both loads and stores (registered)
mem_ctrl_busy  in  1  mem ctrl cannot accept a request this cycle
mem_load_done  in  1  one-cycle completion pulse for the outstanding request
mem_ctrl_read_in  in  XLEN  load data, right-justified; valid while done=1

Behaviour:
- Reset, async: FSM goes to IDLE, store buffer is emptied (pending stores are discarded), all outputs are 0 except sb_empty_o=1.
- Pass-through: out_rd_* are combinational copies of input_rd_*, except a completing load replaces out_rd_data. While stalled, out_write_or_not=0.
- Forward: mem_forward_* equal out_rd_* whenever out_write_or_not=1, otherwise 0.
- Store buffer: a circular FIFO of {addr, data, byte mask, size}.
  - A store enqueues in the cycle it is presented if count<SB_DEPTH, or if a drain completes in the same cycle. It does not stall.
  - If the buffer is full and no drain completes, stall_from_mem=1.
- Load hazard check: compare the load byte range against every valid entry (same XLEN/8-aligned word, byte-mask overlap).
  - No overlap: issue the load to memory.
  - The youngest overlapping entry has an identical address and size: forward its data, extended per size/unsigned. The load completes in the same cycle with no stall.
  - Any other overlap: stall until the overlapping entries have drained.
- FSM states: IDLE, LOAD_REQ, LOAD_WAIT, DRAIN_REQ, DRAIN_WAIT. At most one memory request is outstanding.
  - IDLE→LOAD_REQ on a non-forwarded, non-hazard load. Loads have priority over draining unless the buffer is full.
  - IDLE→DRAIN_REQ when the buffer is non-empty and no load is pending.
  - *_REQ: hold read_mem/write_mem, address, data and data_len stable. Acceptance is a cycle with the request high and mem_ctrl_busy=0; move to *_WAIT and deassert the request the next cycle.
  - LOAD_WAIT: on mem_load_done, drive the extended result on out_rd_data combinationally, drop stall_from_mem in that cycle, and go to IDLE.
  - DRAIN_WAIT: on mem_load_done, pop the head entry and go to IDLE.
- stall_from_mem=1 while a valid load has not completed, while the buffer is full on a store, or while a hazard wait is in progress.
- Extension: byte/half results are sign-extended to XLEN unless unsigned_in=1. Store data is masked to size.
- Misalignment is not checked; behaviour is undefined.
- rdy_in=0: the FSM, buffer and registered requests freeze. mem_load_done is ignored.

Test Plan:
- Reset asserted during LOAD_WAIT → all outputs 0 immediately, sb_empty_o=1, the later done pulse is ignored.
- Four SW to 0x100..0x10C with busy=1 → no stall for the first 4; a 5th SW stalls until the first drain done; then data_len=4 and addresses drain in FIFO order.
- SW 0x80 data 0xDEADBEEF, then LW 0x80 with busy=1 → rd_data=0xDEADBEEF the same cycle, stall=0, read_mem never asserted.
- SB 0x81 data 0xFF, then LW 0x80 → stall until the drain completes, then read_mem=1 with addr 0x80, data_len=4.
- LB 0x200 with mem ctrl returning 0x00000080 → rd_data=0xFFFFFF80; LBU → 0x00000080; LH with 0x8001 → 0xFFFF8001.
- Busy held high for 3 cycles on a load → read_mem, address and data_len stay stable; acceptance occurs on the first busy=0 cycle; stall remains until done.

Source files
------------

// File: rtl/mem_lsu_sb.sv
// MEM stage with a registered memory-request FSM and a circular store buffer.
// Stores retire into the buffer; loads forward from, wait behind, or bypass buffered stores.
module mem_lsu_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              valid_in,
  input  logic              is_load_in,
  input  logic              is_store_in,
  input  logic [1:0]        size_in,
  input  logic              unsigned_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [XLEN-1:0]   storedata_in,
  input  logic [4:0]        input_rd_addr,
  input  logic [XLEN-1:0]   input_rd_data,
  input  logic              write_or_not,
  output logic [4:0]        out_rd_addr,
  output logic [XLEN-1:0]   out_rd_data,
  output logic              out_write_or_not,
  output logic              mem_forward_id_o,
  output logic [4:0]        mem_forward_addr_o,
  output logic [XLEN-1:0]   mem_forward_data_o,
  output logic              stall_from_mem,
  output logic              sb_empty_o,
  output logic              read_mem,
  output logic              write_mem,
  output logic [ADDR_W-1:0] mem_addr_to_read,
  output logic [XLEN-1:0]   mem_data_to_write,
  output logic [2:0]        data_len,
  input  logic              mem_ctrl_busy,
  input  logic              mem_load_done,
  input  logic [XLEN-1:0]   mem_ctrl_read_in
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_REQ, S_LOAD_WAIT, S_DRAIN_REQ, S_DRAIN_WAIT
  } state_e;

  function automatic int unsigned size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [NB-1:0] byte_mask(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
    logic [NB-1:0] m;
    m = NB'((1 << size_bytes(sz)) - 1);
    return m << a[OFF_W-1:0];
  endfunction

  // Sign/zero-extend the low size bytes of d; also used to mask store data.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [1:0] sz,
                                             input logic uns);
    int unsigned            sh;
    logic [XLEN-1:0]        l;
    logic signed [XLEN-1:0] s;
    sh = XLEN - 8 * size_bytes(sz);
    l  = d << sh;
    s  = $signed(l) >>> sh;
    if (uns) return l >> sh;
    return $unsigned(s);
  endfunction

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  sb_addr_q [SB_DEPTH];
  logic [XLEN-1:0]    sb_data_q [SB_DEPTH];
  logic [NB-1:0]      sb_mask_q [SB_DEPTH];
  logic [1:0]         sb_size_q [SB_DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q, idx;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               read_q, read_d, write_q, write_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [XLEN-1:0]    req_data_q, req_data_d;
  logic [2:0]         req_len_q, req_len_d;

  logic [NB-1:0]      ld_mask;
  logic               ld_v, st_v, full, load_done, drain_done;
  logic               ovl_any, fwd_hit, fwd, st_stall, ld_stall, enq, pop;
  logic [XLEN-1:0]    fwd_data;

  assign ld_v       = valid_in & is_load_in;
  assign st_v       = valid_in & is_store_in;
  assign ld_mask    = byte_mask(mem_addr_in, size_in);
  assign full       = (count_q == CNT_W'(SB_DEPTH));
  assign load_done  = (state_q == S_LOAD_WAIT) & mem_load_done & rdy_in;
  assign drain_done = (state_q == S_DRAIN_WAIT) & mem_load_done & rdy_in;
  assign fwd        = ld_v & ovl_any & fwd_hit;
  assign st_stall   = st_v & full & ~drain_done;
  assign ld_stall   = ld_v & ~fwd & ~load_done;
  assign enq        = st_v & rdy_in & ~st_stall;
  assign pop        = drain_done;
  assign count_d    = count_q + CNT_W'(enq) - CNT_W'(pop);

  // Scan oldest to youngest so the last overlapping entry decides forwarding.
  always_comb begin
    ovl_any  = 1'b0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head_q;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q &&
          sb_addr_q[idx][ADDR_W-1:OFF_W] == mem_addr_in[ADDR_W-1:OFF_W] &&
          |(sb_mask_q[idx] & ld_mask)) begin
        ovl_any  = 1'b1;
        fwd_hit  = (sb_addr_q[idx] == mem_addr_in) && (sb_size_q[idx] == size_in);
        fwd_data = sb_data_q[idx];
      end
    end
  end

  // Request FSM: loads win over draining unless the buffer is full.
  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    write_d    = write_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_len_d  = req_len_q;
    case (state_q)
      S_IDLE: begin
        if (ld_v && !ovl_any && !full) begin
          state_d    = S_LOAD_REQ;
          read_d     = 1'b1;
          req_addr_d = mem_addr_in;
          req_len_d  = 3'(size_bytes(size_in));
        end else if (count_q != '0) begin
          state_d    = S_DRAIN_REQ;
          write_d    = 1'b1;
          req_addr_d = sb_addr_q[head_q];
          req_data_d = sb_data_q[head_q];
          req_len_d  = 3'(size_bytes(sb_size_q[head_q]));
        end
      end
      S_LOAD_REQ: if (!mem_ctrl_busy) begin
        state_d = S_LOAD_WAIT;
        read_d  = 1'b0;
      end
      S_LOAD_WAIT: if (mem_load_done) state_d = S_IDLE;
      S_DRAIN_REQ: if (!mem_ctrl_busy) begin
        state_d = S_DRAIN_WAIT;
        write_d = 1'b0;
      end
      S_DRAIN_WAIT: if (mem_load_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_len_q  <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_data_q[i] <= '0;
        sb_mask_q[i] <= '0;
        sb_size_q[i] <= '0;
      end
    end else if (rdy_in) begin
      state_q    <= state_d;
      count_q    <= count_d;
      read_q     <= read_d;
      write_q    <= write_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_len_q  <= req_len_d;
      if (enq) begin
        sb_addr_q[tail_q] <= mem_addr_in;
        sb_data_q[tail_q] <= extend(storedata_in, size_in, 1'b1);
        sb_mask_q[tail_q] <= ld_mask;
        sb_size_q[tail_q] <= size_in;
        tail_q            <= tail_q + PTR_W'(1);
      end
      if (pop) head_q <= head_q + PTR_W'(1);
    end
  end

  // Writeback/forward path is combinational but forced to zero while reset is held.
  always_comb begin
    out_rd_addr      = '0;
    out_rd_data      = '0;
    out_write_or_not = 1'b0;
    stall_from_mem   = 1'b0;
    if (!rst_in) begin
      stall_from_mem   = ld_stall | st_stall;
      out_rd_addr      = input_rd_addr;
      out_rd_data      = load_done ? extend(mem_ctrl_read_in, size_in, unsigned_in) :
                         fwd       ? extend(fwd_data, size_in, unsigned_in) : input_rd_data;
      out_write_or_not = write_or_not & ~(ld_stall | st_stall);
    end
  end

  assign mem_forward_id_o   = out_write_or_not;
  assign mem_forward_addr_o = out_write_or_not ? out_rd_addr : '0;
  assign mem_forward_data_o = out_write_or_not ? out_rd_data : '0;
  assign sb_empty_o         = (count_q == '0) &&
                              (state_q != S_DRAIN_REQ) && (state_q != S_DRAIN_WAIT);
  assign read_mem           = read_q;
  assign write_mem          = write_q;
  assign mem_addr_to_read   = req_addr_q;
  assign mem_data_to_write  = req_data_q;
  assign data_len           = req_len_q;

endmodule

// File: tb/tb_mem_lsu_sb.sv
// Directed bench for mem_lsu_sb: reset, pass-through, loads, store buffering,
// store-to-load forwarding, overlap hazards and reset during an outstanding load.
module tb_mem_lsu_sb;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, valid_in, is_load_in, is_store_in, unsigned_in;
  logic [1:0]  size_in;
  logic [31:0] mem_addr_in, storedata_in, input_rd_data;
  logic [4:0]  input_rd_addr;
  logic        write_or_not;
  logic [4:0]  out_rd_addr, mem_forward_addr_o;
  logic [31:0] out_rd_data, mem_forward_data_o;
  logic        out_write_or_not, mem_forward_id_o, stall_from_mem, sb_empty_o;
  logic        read_mem, write_mem;
  logic [31:0] mem_addr_to_read, mem_data_to_write;
  logic [2:0]  data_len;
  logic        mem_ctrl_busy, mem_load_done;
  logic [31:0] mem_ctrl_read_in;

  int checks   = 0;
  int failures = 0;

  mem_lsu_sb #(.XLEN(32), .ADDR_W(32), .SB_DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .valid_in(valid_in),
    .is_load_in(is_load_in), .is_store_in(is_store_in), .size_in(size_in),
    .unsigned_in(unsigned_in), .mem_addr_in(mem_addr_in), .storedata_in(storedata_in),
    .input_rd_addr(input_rd_addr), .input_rd_data(input_rd_data), .write_or_not(write_or_not),
    .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data), .out_write_or_not(out_write_or_not),
    .mem_forward_id_o(mem_forward_id_o), .mem_forward_addr_o(mem_forward_addr_o),
    .mem_forward_data_o(mem_forward_data_o), .stall_from_mem(stall_from_mem),
    .sb_empty_o(sb_empty_o), .read_mem(read_mem), .write_mem(write_mem),
    .mem_addr_to_read(mem_addr_to_read), .mem_data_to_write(mem_data_to_write),
    .data_len(data_len), .mem_ctrl_busy(mem_ctrl_busy), .mem_load_done(mem_load_done),
    .mem_ctrl_read_in(mem_ctrl_read_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_in);
  endtask

  task automatic op_idle();
    valid_in = 1'b0; is_load_in = 1'b0; is_store_in = 1'b0; size_in = 2'd0;
    unsigned_in = 1'b0; mem_addr_in = '0; storedata_in = '0;
    input_rd_addr = '0; input_rd_data = '0; write_or_not = 1'b0;
  endtask

  task automatic op_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    op_idle();
    valid_in = 1'b1; is_store_in = 1'b1; size_in = sz; mem_addr_in = a; storedata_in = d;
  endtask

  task automatic op_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         input logic [4:0] rd);
    op_idle();
    valid_in = 1'b1; is_load_in = 1'b1; size_in = sz; unsigned_in = uns; mem_addr_in = a;
    input_rd_addr = rd; input_rd_data = 32'hBAD0BAD0; write_or_not = 1'b1;
  endtask

  // Load with an idle memory controller: issue, accept, complete on the third cycle.
  task automatic run_load(input string t, input logic [31:0] a, input logic [1:0] sz,
                          input logic uns, input logic [31:0] memval, input logic [31:0] exp,
                          input logic [2:0] len);
    tick(); op_load(a, sz, uns, 5'd3); mem_ctrl_busy = 1'b0; mem_load_done = 1'b0;
    sample(); check_eq({t, "_stall_issue"}, 64'(stall_from_mem), 64'(1));
    tick(); sample();
    check_eq({t, "_read_mem"}, 64'(read_mem), 64'(1));
    check_eq({t, "_addr"}, 64'(mem_addr_to_read), 64'(a));
    check_eq({t, "_len"}, 64'(data_len), 64'(len));
    tick(); mem_load_done = 1'b1; mem_ctrl_read_in = memval;
    sample();
    check_eq({t, "_rd_data"}, 64'(out_rd_data), 64'(exp));
    check_eq({t, "_stall_done"}, 64'(stall_from_mem), 64'(0));
    check_eq({t, "_fwd_data"}, 64'(mem_forward_data_o), 64'(exp));
    tick(); mem_load_done = 1'b0; op_idle();
  endtask

  initial begin
    op_idle();
    rst_in = 1'b1; rdy_in = 1'b1; mem_ctrl_busy = 1'b0; mem_load_done = 1'b0;
    mem_ctrl_read_in = '0;
    input_rd_addr = 5'd9; input_rd_data = 32'h1234; write_or_not = 1'b1;

    // Reset state with live pass-through inputs.
    sample();
    check_eq("rst_rd_addr", 64'(out_rd_addr), 64'(0));
    check_eq("rst_rd_data", 64'(out_rd_data), 64'(0));
    check_eq("rst_wr", 64'(out_write_or_not), 64'(0));
    check_eq("rst_fwd_id", 64'(mem_forward_id_o), 64'(0));
    check_eq("rst_stall", 64'(stall_from_mem), 64'(0));
    check_eq("rst_sb_empty", 64'(sb_empty_o), 64'(1));
    check_eq("rst_read", 64'(read_mem), 64'(0));
    check_eq("rst_write", 64'(write_mem), 64'(0));
    check_eq("rst_len", 64'(data_len), 64'(0));
    tick(); rst_in = 1'b0; op_idle();

    // ALU result passes straight through and forwards to ID.
    tick(); valid_in = 1'b1; input_rd_addr = 5'd4; input_rd_data = 32'h55; write_or_not = 1'b1;
    sample();
    check_eq("pt_rd_data", 64'(out_rd_data), 64'(32'h55));
    check_eq("pt_wr", 64'(out_write_or_not), 64'(1));
    check_eq("pt_fwd_addr", 64'(mem_forward_addr_o), 64'(4));
    check_eq("pt_fwd_data", 64'(mem_forward_data_o), 64'(32'h55));

    run_load("lb", 32'h200, 2'd0, 1'b0, 32'h00000080, 32'hFFFFFF80, 3'd1);
    run_load("lbu", 32'h200, 2'd0, 1'b1, 32'h00000080, 32'h00000080, 3'd1);

    // LH with the controller busy for three request cycles plus one frozen cycle.
    tick(); op_load(32'h204, 2'd1, 1'b0, 5'd3); mem_ctrl_busy = 1'b1;
    sample();
    check_eq("lh_stall0", 64'(stall_from_mem), 64'(1));
    check_eq("lh_read0", 64'(read_mem), 64'(0));
    for (int c = 0; c < 3; c++) begin
      tick(); sample();
      check_eq("lh_busy_read", 64'(read_mem), 64'(1));
      check_eq("lh_busy_addr", 64'(mem_addr_to_read), 64'(32'h204));
      check_eq("lh_busy_len", 64'(data_len), 64'(2));
      check_eq("lh_busy_stall", 64'(stall_from_mem), 64'(1));
    end
    tick(); mem_ctrl_busy = 1'b0; rdy_in = 1'b0;
    sample(); check_eq("lh_frozen_read", 64'(read_mem), 64'(1));
    tick(); rdy_in = 1'b1;
    sample(); check_eq("lh_hold_read", 64'(read_mem), 64'(1));
    tick(); sample();
    check_eq("lh_accepted", 64'(read_mem), 64'(0));
    check_eq("lh_wait_stall", 64'(stall_from_mem), 64'(1));
    tick(); mem_load_done = 1'b1; mem_ctrl_read_in = 32'h00008001;
    sample();
    check_eq("lh_rd_data", 64'(out_rd_data), 64'(32'hFFFF8001));
    check_eq("lh_stall_done", 64'(stall_from_mem), 64'(0));
    check_eq("lh_wr", 64'(out_write_or_not), 64'(1));
    tick(); mem_load_done = 1'b0; op_idle();

    // Four stores fill the buffer without stalling; the fifth waits for a drain.
    mem_ctrl_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); op_store(32'h100 + 32'(4 * k), 32'hA0 + 32'(k), 2'd2);
      sample(); check_eq("sb_fill_stall", 64'(stall_from_mem), 64'(0));
    end
    tick(); op_store(32'h110, 32'hA4, 2'd2);
    sample();
    check_eq("sb_full_stall", 64'(stall_from_mem), 64'(1));
    check_eq("sb_full_write", 64'(write_mem), 64'(1));
    check_eq("sb_full_addr", 64'(mem_addr_to_read), 64'(32'h100));
    check_eq("sb_full_data", 64'(mem_data_to_write), 64'(32'hA0));
    check_eq("sb_full_len", 64'(data_len), 64'(4));
    check_eq("sb_full_empty", 64'(sb_empty_o), 64'(0));
    tick(); mem_ctrl_busy = 1'b0;
    sample(); check_eq("sb_full_stall2", 64'(stall_from_mem), 64'(1));
    tick(); sample();
    check_eq("sb_wait_stall", 64'(stall_from_mem), 64'(1));
    check_eq("sb_wait_write", 64'(write_mem), 64'(0));
    tick(); mem_load_done = 1'b1;
    sample(); check_eq("sb_drain_unstall", 64'(stall_from_mem), 64'(0));
    for (int k = 1; k < 5; k++) begin
      tick(); mem_load_done = 1'b0; op_idle();
      tick(); sample();
      check_eq("sb_order_write", 64'(write_mem), 64'(1));
      check_eq("sb_order_addr", 64'(mem_addr_to_read), 64'(32'h100 + 32'(4 * k)));
      check_eq("sb_order_data", 64'(mem_data_to_write), 64'(32'hA0 + 32'(k)));
      tick(); mem_load_done = 1'b1;
    end
    tick(); mem_load_done = 1'b0;
    sample();
    check_eq("sb_drained_empty", 64'(sb_empty_o), 64'(1));
    check_eq("sb_drained_write", 64'(write_mem), 64'(0));

    // SW then LW to the same word forwards without touching memory.
    mem_ctrl_busy = 1'b1;
    tick(); op_store(32'h80, 32'hDEADBEEF, 2'd2);
    sample(); check_eq("fw_st_stall", 64'(stall_from_mem), 64'(0));
    tick(); op_load(32'h80, 2'd2, 1'b0, 5'd7);
    sample();
    check_eq("fw_rd_data", 64'(out_rd_data), 64'(32'hDEADBEEF));
    check_eq("fw_stall", 64'(stall_from_mem), 64'(0));
    check_eq("fw_read", 64'(read_mem), 64'(0));
    check_eq("fw_fwd_addr", 64'(mem_forward_addr_o), 64'(7));
    tick(); op_idle();
    sample();
    check_eq("fw_read_after", 64'(read_mem), 64'(0));
    check_eq("fw_drain_write", 64'(write_mem), 64'(1));
    check_eq("fw_drain_data", 64'(mem_data_to_write), 64'(32'hDEADBEEF));
    tick(); mem_ctrl_busy = 1'b0;
    tick(); mem_load_done = 1'b1;
    sample(); check_eq("fw_inflight_empty", 64'(sb_empty_o), 64'(0));
    tick(); mem_load_done = 1'b0;
    sample(); check_eq("fw_done_empty", 64'(sb_empty_o), 64'(1));

    // SB 0x81 partially overlaps LW 0x80: the load waits for the drain, then issues.
    tick(); op_store(32'h81, 32'h123456FF, 2'd0);
    sample(); check_eq("hz_st_stall", 64'(stall_from_mem), 64'(0));
    tick(); op_load(32'h80, 2'd2, 1'b0, 5'd8);
    sample();
    check_eq("hz_stall", 64'(stall_from_mem), 64'(1));
    check_eq("hz_wr", 64'(out_write_or_not), 64'(0));
    tick(); sample();
    check_eq("hz_drain_write", 64'(write_mem), 64'(1));
    check_eq("hz_drain_addr", 64'(mem_addr_to_read), 64'(32'h81));
    check_eq("hz_drain_data", 64'(mem_data_to_write), 64'(32'hFF));
    check_eq("hz_drain_len", 64'(data_len), 64'(1));
    check_eq("hz_no_read", 64'(read_mem), 64'(0));
    tick(); mem_load_done = 1'b1;
    sample(); check_eq("hz_stall_wait", 64'(stall_from_mem), 64'(1));
    tick(); mem_load_done = 1'b0;
    sample();
    check_eq("hz_stall_idle", 64'(stall_from_mem), 64'(1));
    check_eq("hz_no_read2", 64'(read_mem), 64'(0));
    tick(); sample();
    check_eq("hz_read", 64'(read_mem), 64'(1));
    check_eq("hz_read_addr", 64'(mem_addr_to_read), 64'(32'h80));
    check_eq("hz_read_len", 64'(data_len), 64'(4));
    tick(); mem_load_done = 1'b1; mem_ctrl_read_in = 32'h11223344;
    sample();
    check_eq("hz_rd_data", 64'(out_rd_data), 64'(32'h11223344));
    check_eq("hz_stall_done", 64'(stall_from_mem), 64'(0));
    tick(); mem_load_done = 1'b0; op_idle();

    // Reset during LOAD_WAIT discards the buffered store and the late done pulse.
    mem_ctrl_busy = 1'b1;
    tick(); op_store(32'h400, 32'h77, 2'd2);
    tick(); op_load(32'h300, 2'd2, 1'b0, 5'd4);
    tick(); mem_ctrl_busy = 1'b0;
    sample();
    check_eq("rl_read", 64'(read_mem), 64'(1));
    check_eq("rl_no_write", 64'(write_mem), 64'(0));
    tick(); sample();
    check_eq("rl_wait_empty", 64'(sb_empty_o), 64'(0));
    check_eq("rl_wait_stall", 64'(stall_from_mem), 64'(1));
    #2 rst_in = 1'b1;
    #1;
    check_eq("rl_rd_data", 64'(out_rd_data), 64'(0));
    check_eq("rl_rd_addr", 64'(out_rd_addr), 64'(0));
    check_eq("rl_stall", 64'(stall_from_mem), 64'(0));
    check_eq("rl_sb_empty", 64'(sb_empty_o), 64'(1));
    check_eq("rl_wr", 64'(out_write_or_not), 64'(0));
    tick(); rst_in = 1'b0; op_idle(); mem_load_done = 1'b1; mem_ctrl_read_in = 32'hAAAA;
    sample();
    check_eq("rl_late_rd_data", 64'(out_rd_data), 64'(0));
    check_eq("rl_late_read", 64'(read_mem), 64'(0));
    check_eq("rl_late_empty", 64'(sb_empty_o), 64'(1));
    tick(); mem_load_done = 1'b0;
    sample(); check_eq("rl_no_drain", 64'(write_mem), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
